// File: rtl/stepper_seq_ctrl_if.sv
// rtl/stepper_seq_ctrl_if.sv - command/status bundle between the register layer and the stepper sequencer
//
// Purpose: groups the move command inputs and the coil/status outputs of stepper_seq_ctrl.
// Signals:
//   start, stop          move control pulses (master -> slave)
//   dir, half_mode       direction and step mode, latched at start
//   hold_en              keep coils energised while idle (live)
//   period_cycles        clk cycles per step (0 = default period)
//   steps_req            steps to move (0 = continuous)
//   coil_out, phase      coil drive pattern and phase index (slave -> master)
//   busy, done           move in progress / end-of-move pulse
//   step_pulse           one-cycle pulse per phase advance
//   steps_left           remaining steps of a counted move
interface stepper_seq_ctrl_if #(
  parameter int CNT_W  = 24,
  parameter int STEP_W = 16
);
  logic              start;
  logic              stop;
  logic              dir;
  logic              half_mode;
  logic              hold_en;
  logic [CNT_W-1:0]  period_cycles;
  logic [STEP_W-1:0] steps_req;
  logic [3:0]        coil_out;
  logic [2:0]        phase;
  logic              busy;
  logic              done;
  logic              step_pulse;
  logic [STEP_W-1:0] steps_left;

  modport master (
    output start, stop, dir, half_mode, hold_en, period_cycles, steps_req,
    input  coil_out, phase, busy, done, step_pulse, steps_left
  );

  modport slave (
    input  start, stop, dir, half_mode, hold_en, period_cycles, steps_req,
    output coil_out, phase, busy, done, step_pulse, steps_left
  );
endinterface

// File: rtl/stepper_seq_ctrl.sv
// rtl/stepper_seq_ctrl.sv - bipolar stepper sequencer with full/half step, counted and continuous moves
//
// Purpose: advances an 8-entry coil phase table at a programmable rate in either direction,
//   for a counted number of steps or until stopped, and drives the H-bridge coil pins.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    stepper_seq_ctrl_if.slave (command inputs, coil and status outputs)
module stepper_seq_ctrl #(
  parameter int CNT_W      = 24,
  parameter int STEP_W     = 16,
  parameter int DEF_PERIOD = 500000
) (
  input  logic              clk,
  input  logic              rst_n,
  stepper_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_phase;
  logic              r_dir;
  logic              r_half;
  logic              r_counted;
  logic              r_moved;
  logic              r_step_pulse;
  logic [CNT_W-1:0]  r_period;
  logic [CNT_W-1:0]  r_tick;
  logic [STEP_W-1:0] r_steps_left;

  logic              w_step;
  logic              w_last;
  logic              w_busy;
  logic [2:0]        w_stride;
  logic [2:0]        w_phase_nxt;
  logic [3:0]        w_pattern;

  assign w_busy = (r_state == S_RUN);
  assign w_step = w_busy && ((r_tick + CNT_W'(1)) == r_period);
  assign w_last = r_counted && (r_steps_left == STEP_W'(1));

  // Full mode from an odd phase takes a single step to get back onto even indices.
  assign w_stride    = (r_half || r_phase[0]) ? 3'd1 : 3'd2;
  // 3-bit arithmetic gives the mod-8 wrap in both directions.
  assign w_phase_nxt = r_dir ? (r_phase - w_stride) : (r_phase + w_stride);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Stop has priority over a coincident step; start is only honoured in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
      S_RUN:   if (bus.stop || (w_step && w_last)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase      <= 3'd0;
      r_dir        <= 1'b0;
      r_half       <= 1'b0;
      r_counted    <= 1'b0;
      r_moved      <= 1'b0;
      r_step_pulse <= 1'b0;
      r_period     <= CNT_W'(1);
      r_tick       <= '0;
      r_steps_left <= '0;
    end else begin
      r_step_pulse <= 1'b0;
      if (r_state == S_IDLE && bus.start) begin
        r_dir        <= bus.dir;
        r_half       <= bus.half_mode;
        r_period     <= (bus.period_cycles == '0) ? CNT_W'(DEF_PERIOD) : bus.period_cycles;
        r_counted    <= (bus.steps_req != '0);
        r_steps_left <= bus.steps_req;
        r_tick       <= '0;
        r_moved      <= 1'b1;
      end else if (w_busy && !bus.stop) begin
        if (w_step) begin
          r_phase      <= w_phase_nxt;
          r_step_pulse <= 1'b1;
          r_tick       <= '0;
          if (r_counted) r_steps_left <= r_steps_left - STEP_W'(1);
        end else begin
          r_tick <= r_tick + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    w_pattern = 4'b0000;
    case (r_phase)
      3'd0: w_pattern = 4'b0101;
      3'd1: w_pattern = 4'b0111;
      3'd2: w_pattern = 4'b0110;
      3'd3: w_pattern = 4'b1110;
      3'd4: w_pattern = 4'b1010;
      3'd5: w_pattern = 4'b1011;
      3'd6: w_pattern = 4'b1001;
      3'd7: w_pattern = 4'b1101;
      default: w_pattern = 4'b0000;
    endcase
  end

  // Coils stay dark after reset until a move has actually been started.
  assign bus.coil_out   = (r_moved && (w_busy || bus.hold_en)) ? w_pattern : 4'b0000;
  assign bus.phase      = r_phase;
  assign bus.busy       = w_busy;
  assign bus.done       = (r_state == S_DONE);
  assign bus.step_pulse = r_step_pulse;
  assign bus.steps_left = r_steps_left;

endmodule

// File: tb/tb_stepper_seq_ctrl.sv
// tb/tb_stepper_seq_ctrl.sv - self-checking bench for stepper_seq_ctrl
module tb_stepper_seq_ctrl;
  localparam int CNT_W  = 24;
  localparam int STEP_W = 16;
  localparam int DEF    = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stepper_seq_ctrl_if #(.CNT_W(CNT_W), .STEP_W(STEP_W)) bus();

  stepper_seq_ctrl #(.CNT_W(CNT_W), .STEP_W(STEP_W), .DEF_PERIOD(DEF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int m_phase = 0;
  bit m_moved = 1'b0;
  bit [3:0] tbl [0:7] = '{4'b0101, 4'b0111, 4'b0110, 4'b1110,
                          4'b1010, 4'b1011, 4'b1001, 4'b1101};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int adv(input int p, input bit d, input bit h);
    int s;
    s = (h || (p % 2 == 1)) ? 1 : 2;
    return d ? (p - s + 8) % 8 : (p + s) % 8;
  endfunction

  task automatic expect_st(input string tag, input bit busy, input bit done, input bit sp, input int sl);
    logic [3:0] c;
    c = (busy || (m_moved && bus.hold_en)) ? tbl[m_phase] : 4'b0000;
    chk({tag, " busy"}, 32'(bus.busy), 32'(busy));
    chk({tag, " done"}, 32'(bus.done), 32'(done));
    chk({tag, " step_pulse"}, 32'(bus.step_pulse), 32'(sp));
    chk({tag, " phase"}, 32'(bus.phase), 32'(m_phase));
    chk({tag, " steps_left"}, 32'(bus.steps_left), 32'(sl));
    chk({tag, " coil"}, 32'(bus.coil_out), 32'(c));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_phase = 0;
    m_moved = 1'b0;
  endtask

  // One move: start pulse, then cycle-by-cycle comparison against the step schedule
  // (steps at multiples of P after start), with starts poked while busy and in DONE.
  task automatic do_move(input bit d, input bit h, input int period, input int n,
                         input int stop_at, input bit hold, input bit idle_stop, input string tag);
    int  p;
    int  total;
    int  nsteps;
    bit  sp;
    p = (period == 0) ? DEF : period;
    total = (stop_at != 0) ? stop_at : n * p;
    @(negedge clk);
    bus.dir = d;
    bus.half_mode = h;
    bus.period_cycles = CNT_W'(period);
    bus.steps_req = STEP_W'(n);
    bus.hold_en = hold;
    bus.start = 1'b1;
    bus.stop = idle_stop;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop = 1'b0;
    m_moved = 1'b1;
    nsteps = 0;
    expect_st({tag, " launch"}, 1'b1, 1'b0, 1'b0, n);
    for (int k = 1; k <= total; k++) begin
      bus.start = (k == 1 || k == total);
      bus.stop = (k == stop_at);
      @(negedge clk);
      bus.start = 1'b0;
      bus.stop = 1'b0;
      sp = (k != stop_at) && (k % p == 0);
      if (sp) begin
        m_phase = adv(m_phase, d, h);
        nsteps++;
      end
      expect_st(tag, k < total, k == total, sp, (n == 0) ? 0 : n - nsteps);
    end
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    expect_st({tag, " idle"}, 1'b0, 1'b0, 1'b0, (n == 0) ? 0 : n - nsteps);
  endtask

  initial begin
    int d, h, per, n, sa, p;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.dir = 1'b0;
    bus.half_mode = 1'b1;
    bus.hold_en = 1'b1;
    bus.period_cycles = '0;
    bus.steps_req = '0;

    do_reset();
    @(negedge clk);
    expect_st("reset", 1'b0, 1'b0, 1'b0, 0);

    do_move(1'b0, 1'b1, 4, 10, 0, 1'b1, 1'b0, "t1_half_fwd");
    chk("t1 final phase", 32'(bus.phase), 32'd2);

    do_reset();
    do_move(1'b1, 1'b0, 3, 5, 0, 1'b1, 1'b0, "t2_full_rev");
    chk("t2 final phase", 32'(bus.phase), 32'd6);
    chk("t2 final coil", 32'(bus.coil_out), 32'b1001);

    do_move(1'b0, 1'b1, 2, 5, 0, 1'b1, 1'b0, "t3_half_to3");
    chk("t3 odd phase", 32'(bus.phase), 32'd3);
    do_move(1'b0, 1'b0, 2, 3, 0, 1'b1, 1'b0, "t3_realign");
    chk("t3 realigned phase", 32'(bus.phase), 32'd0);

    do_move(1'b0, 1'b1, 2, 0, 6, 1'b1, 1'b0, "t4_cont_stop");
    chk("t4 final phase", 32'(bus.phase), 32'd2);

    do_move(1'b0, 1'b0, 0, 1, 0, 1'b1, 1'b1, "t5_default_period");
    chk("t5 final phase", 32'(bus.phase), 32'd4);

    for (int i = 0; i < 24; i++) begin
      d = $urandom % 2;
      h = $urandom % 2;
      per = $urandom_range(0, 5);
      n = $urandom_range(0, 6);
      p = (per == 0) ? DEF : per;
      if (n == 0) sa = $urandom_range(1, 3 * p);
      else if ($urandom % 3 == 0) sa = $urandom_range(1, n * p);
      else sa = 0;
      do_move(d[0], h[0], per, n, sa, 1'($urandom % 2), 1'($urandom % 2), $sformatf("rnd%0d", i));
    end

    // hold_en acts live while idle
    @(negedge clk);
    bus.hold_en = 1'b0;
    #1;
    chk("hold off coil", 32'(bus.coil_out), 32'd0);
    bus.hold_en = 1'b1;
    #1;
    chk("hold on coil", 32'(bus.coil_out), 32'(tbl[m_phase]));

    do_reset();
    do_move(1'b0, 1'b1, 1, 3, 0, 1'b0, 1'b0, "t6_nohold");
    chk("t6 idle coil dark", 32'(bus.coil_out), 32'd0);

    // asynchronous reset mid-move
    @(negedge clk);
    bus.half_mode = 1'b1;
    bus.dir = 1'b0;
    bus.period_cycles = CNT_W'(2);
    bus.steps_req = '0;
    bus.hold_en = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6 pre-reset phase", 32'(bus.phase), 32'(m_phase + 2) % 8);
    chk("t6 pre-reset busy", 32'(bus.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    m_phase = 0;
    m_moved = 1'b0;
    expect_st("t6 async reset", 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_st("t6 after reset", 1'b0, 1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
